// File: rtl/pardef.sv
// Shared write-back definitions: register index constants and the FSM state encoding.
// Ports: none (package).
package pardef;

  // Writing this index goes to the PC redirect port, not the register file.
  localparam logic [4:0] PC_IDX = 5'h0F;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WR_RD = 2'd1,
    WR_RN = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb.sv
// Write-back stage: captures the memory-stage result bundle and retires up to two
// register writes through one write port, steering index 15 to the PC redirect port.
// Ports: nGCLK/nRESET clock and async active-low reset; nWAIT global enable;
//   wb_enbar stage enable (active low); *_me memory-stage bundle in; rf_wr_* register-file port;
//   pc_wr_* / pc_from_load PC redirect; wb_busy stall to memory stage; *_wb latched bundle for forwarding.
module wb
  import pardef::*;
(
  input  logic        nGCLK,
  input  logic        nRESET,
  input  logic        nWAIT,
  input  logic        wb_enbar,
  input  logic [31:0] me_result,
  input  logic [31:0] base_me,
  input  logic [4:0]  Rd_me,
  input  logic [4:0]  Rn_me,
  input  logic        write_Rd_me,
  input  logic        write_Rn_me,
  input  logic        load_pc,
  input  logic        stop_me,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        pc_wr_en,
  output logic [31:0] pc_wr_data,
  output logic        pc_from_load,
  output logic        wb_busy,
  output logic [31:0] wb_result,
  output logic [4:0]  Rd_wb,
  output logic        write_Rd_wb,
  output logic [31:0] base_wb,
  output logic [4:0]  Rn_wb,
  output logic        write_Rn_wb,
  output logic        stop_wb
);

  wb_state_t   state;
  wb_state_t   state_nxt;
  logic        ld_pc_wb;
  logic        capture_ok;
  logic        do_capture;
  logic        clr_rd;
  logic        clr_rn;
  logic        rn_req;
  logic        active;
  logic        is_pc;
  logic [4:0]  act_idx;
  logic [31:0] act_data;

  // When both requests name the same register, Rd wins and the Rn write is dropped.
  assign rn_req     = write_Rn_me & ~(write_Rd_me & (Rd_me == Rn_me));
  assign wb_busy    = (state == WR_RD) & write_Rn_wb;
  assign capture_ok = nWAIT & ~wb_enbar & ~wb_busy;

  // Next state and per-cycle control. Nothing advances while nWAIT is low.
  always_comb begin
    state_nxt  = state;
    do_capture = 1'b0;
    clr_rd     = 1'b0;
    clr_rn     = 1'b0;
    if (nWAIT) begin
      case (state)
        EMPTY: begin
          if (capture_ok) do_capture = 1'b1;
        end
        WR_RD: begin
          clr_rd = 1'b1;
          if (write_Rn_wb)     state_nxt  = WR_RN;
          else if (capture_ok) do_capture = 1'b1;
          else                 state_nxt  = EMPTY;
        end
        WR_RN: begin
          clr_rn = 1'b1;
          if (capture_ok) do_capture = 1'b1;
          else            state_nxt  = EMPTY;
        end
        default: state_nxt = EMPTY;
      endcase
      if (do_capture) begin
        if (write_Rd_me)  state_nxt = WR_RD;
        else if (rn_req)  state_nxt = WR_RN;
        else              state_nxt = EMPTY;
      end
    end
  end

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) state <= EMPTY;
    else         state <= state_nxt;
  end

  // Latched bundle. A retired write clears its flag so forwarding only sees pending
  // writes; a capture in the same cycle takes priority over the clear.
  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      wb_result   <= '0;
      base_wb     <= '0;
      Rd_wb       <= '0;
      Rn_wb       <= '0;
      write_Rd_wb <= 1'b0;
      write_Rn_wb <= 1'b0;
      ld_pc_wb    <= 1'b0;
      stop_wb     <= 1'b0;
    end else if (do_capture) begin
      wb_result   <= me_result;
      base_wb     <= base_me;
      Rd_wb       <= Rd_me;
      Rn_wb       <= Rn_me;
      write_Rd_wb <= write_Rd_me;
      write_Rn_wb <= rn_req;
      ld_pc_wb    <= load_pc;
      stop_wb     <= stop_me;
    end else begin
      if (clr_rd) write_Rd_wb <= 1'b0;
      if (clr_rn) write_Rn_wb <= 1'b0;
    end
  end

  // Write port: the state selects which half of the bundle is on the port.
  always_comb begin
    act_idx  = 5'd0;
    act_data = 32'd0;
    active   = 1'b0;
    case (state)
      WR_RD: begin
        act_idx  = Rd_wb;
        act_data = wb_result;
        active   = 1'b1;
      end
      WR_RN: begin
        act_idx  = Rn_wb;
        act_data = base_wb;
        active   = 1'b1;
      end
      default: ;
    endcase
  end

  assign is_pc        = active & (act_idx == PC_IDX);
  assign rf_wr_en     = active & ~is_pc & nWAIT;
  assign pc_wr_en     = is_pc & nWAIT;
  assign rf_wr_addr   = act_idx;
  assign rf_wr_data   = act_data;
  assign pc_wr_data   = act_data;
  assign pc_from_load = pc_wr_en & ld_pc_wb;

endmodule

// File: tb/tb_wb.sv
module tb_wb;

  logic        nGCLK;
  logic        nRESET;
  logic        nWAIT;
  logic        wb_enbar;
  logic [31:0] me_result;
  logic [31:0] base_me;
  logic [4:0]  Rd_me;
  logic [4:0]  Rn_me;
  logic        write_Rd_me;
  logic        write_Rn_me;
  logic        load_pc;
  logic        stop_me;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        pc_wr_en;
  logic [31:0] pc_wr_data;
  logic        pc_from_load;
  logic        wb_busy;
  logic [31:0] wb_result;
  logic [4:0]  Rd_wb;
  logic        write_Rd_wb;
  logic [31:0] base_wb;
  logic [4:0]  Rn_wb;
  logic        write_Rn_wb;
  logic        stop_wb;

  int vectors;
  int miscompares;

  wb dut (
    .nGCLK(nGCLK), .nRESET(nRESET), .nWAIT(nWAIT), .wb_enbar(wb_enbar),
    .me_result(me_result), .base_me(base_me), .Rd_me(Rd_me), .Rn_me(Rn_me),
    .write_Rd_me(write_Rd_me), .write_Rn_me(write_Rn_me), .load_pc(load_pc),
    .stop_me(stop_me), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data),
    .pc_from_load(pc_from_load), .wb_busy(wb_busy), .wb_result(wb_result),
    .Rd_wb(Rd_wb), .write_Rd_wb(write_Rd_wb), .base_wb(base_wb), .Rn_wb(Rn_wb),
    .write_Rn_wb(write_Rn_wb), .stop_wb(stop_wb)
  );

  initial nGCLK = 1'b0;
  always #5 nGCLK = ~nGCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge nGCLK);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic [4:0] rn, input logic wrd,
                       input logic wrn, input logic [31:0] res, input logic [31:0] base,
                       input logic lpc, input logic stp);
    wb_enbar    = 1'b0;
    Rd_me       = rd;
    Rn_me       = rn;
    write_Rd_me = wrd;
    write_Rn_me = wrn;
    me_result   = res;
    base_me     = base;
    load_pc     = lpc;
    stop_me     = stp;
  endtask

  task automatic idle();
    wb_enbar    = 1'b1;
    write_Rd_me = 1'b0;
    write_Rn_me = 1'b0;
    load_pc     = 1'b0;
    stop_me     = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nRESET      = 1'b0;
    nWAIT       = 1'b1;
    me_result   = '0;
    base_me     = '0;
    Rd_me       = '0;
    Rn_me       = '0;
    idle();

    // Reset state
    #2;
    chk("rst_rf_en",  32'(rf_wr_en), 32'd0);
    chk("rst_pc_en",  32'(pc_wr_en), 32'd0);
    chk("rst_busy",   32'(wb_busy), 32'd0);
    chk("rst_result", wb_result, 32'd0);
    tick();
    nRESET = 1'b1;
    tick();

    // Single write
    drive(5'd3, 5'd0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    tick();
    idle();
    chk("single_en",   32'(rf_wr_en), 32'd1);
    chk("single_addr", 32'(rf_wr_addr), 32'd3);
    chk("single_data", rf_wr_data, 32'hDEADBEEF);
    chk("single_busy", 32'(wb_busy), 32'd0);
    chk("single_fwd",  32'(write_Rd_wb), 32'd1);
    tick();
    chk("single_done_en",  32'(rf_wr_en), 32'd0);
    chk("single_done_fwd", 32'(write_Rd_wb), 32'd0);
    chk("single_retained", wb_result, 32'hDEADBEEF);
    chk("single_done_addr", 32'(rf_wr_addr), 32'd0);

    // Dual write
    drive(5'd2, 5'd5, 1'b1, 1'b1, 32'h11, 32'h2000, 1'b0, 1'b0);
    tick();
    chk("dual1_en",   32'(rf_wr_en), 32'd1);
    chk("dual1_addr", 32'(rf_wr_addr), 32'd2);
    chk("dual1_data", rf_wr_data, 32'h11);
    chk("dual1_busy", 32'(wb_busy), 32'd1);
    tick();
    idle();
    chk("dual2_en",   32'(rf_wr_en), 32'd1);
    chk("dual2_addr", 32'(rf_wr_addr), 32'd5);
    chk("dual2_data", rf_wr_data, 32'h2000);
    chk("dual2_busy", 32'(wb_busy), 32'd0);
    chk("dual2_fwd_rd", 32'(write_Rd_wb), 32'd0);
    chk("dual2_fwd_rn", 32'(write_Rn_wb), 32'd1);
    tick();
    chk("dual_done_en",  32'(rf_wr_en), 32'd0);
    chk("dual_done_fwd", 32'(write_Rn_wb), 32'd0);

    // PC load via Rd
    drive(5'd15, 5'd0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0);
    tick();
    idle();
    chk("pc_en",       32'(pc_wr_en), 32'd1);
    chk("pc_data",     pc_wr_data, 32'h100);
    chk("pc_from_ld",  32'(pc_from_load), 32'd1);
    chk("pc_rf_en",    32'(rf_wr_en), 32'd0);
    tick();
    chk("pc_done", 32'(pc_wr_en), 32'd0);

    // PC written through Rn (base write-back to r15), not from a load
    drive(5'd1, 5'd15, 1'b1, 1'b1, 32'h55, 32'h4000, 1'b0, 1'b0);
    tick();
    chk("pcrn1_addr", 32'(rf_wr_addr), 32'd1);
    chk("pcrn1_pc",   32'(pc_wr_en), 32'd0);
    tick();
    idle();
    chk("pcrn2_pc",   32'(pc_wr_en), 32'd1);
    chk("pcrn2_data", pc_wr_data, 32'h4000);
    chk("pcrn2_rf",   32'(rf_wr_en), 32'd0);
    chk("pcrn2_ld",   32'(pc_from_load), 32'd0);
    tick();

    // Rd == Rn: single write of result
    drive(5'd4, 5'd4, 1'b1, 1'b1, 32'hA, 32'hB, 1'b0, 1'b0);
    tick();
    idle();
    chk("same_en",   32'(rf_wr_en), 32'd1);
    chk("same_addr", 32'(rf_wr_addr), 32'd4);
    chk("same_data", rf_wr_data, 32'hA);
    chk("same_busy", 32'(wb_busy), 32'd0);
    chk("same_rn",   32'(write_Rn_wb), 32'd0);
    tick();
    chk("same_done", 32'(rf_wr_en), 32'd0);

    // nWAIT dropped for two cycles during WR_RD with Rn pending
    drive(5'd7, 5'd8, 1'b1, 1'b1, 32'h77, 32'h88, 1'b0, 1'b0);
    tick();
    idle();
    nWAIT = 1'b0;
    #1;
    chk("wait0_en",   32'(rf_wr_en), 32'd0);
    chk("wait0_busy", 32'(wb_busy), 32'd1);
    tick();
    chk("wait1_en",   32'(rf_wr_en), 32'd0);
    chk("wait1_addr", 32'(rf_wr_addr), 32'd7);
    tick();
    chk("wait2_busy", 32'(wb_busy), 32'd1);
    nWAIT = 1'b1;
    #1;
    chk("wait_rd_en",   32'(rf_wr_en), 32'd1);
    chk("wait_rd_data", rf_wr_data, 32'h77);
    tick();
    chk("wait_rn_addr", 32'(rf_wr_addr), 32'd8);
    chk("wait_rn_data", rf_wr_data, 32'h88);
    chk("wait_rn_en",   32'(rf_wr_en), 32'd1);
    tick();
    chk("wait_done", 32'(rf_wr_en), 32'd0);

    // Back-to-back single writes, with stop marker on the second
    drive(5'd1, 5'd0, 1'b1, 1'b0, 32'h1, 32'h0, 1'b0, 1'b0);
    tick();
    drive(5'd6, 5'd0, 1'b1, 1'b0, 32'h6, 32'h0, 1'b0, 1'b1);
    chk("b2b1_addr", 32'(rf_wr_addr), 32'd1);
    tick();
    idle();
    chk("b2b2_en",   32'(rf_wr_en), 32'd1);
    chk("b2b2_addr", 32'(rf_wr_addr), 32'd6);
    chk("b2b2_stop", 32'(stop_wb), 32'd1);
    tick();
    chk("b2b_done", 32'(rf_wr_en), 32'd0);

    // Reset during WR_RD with Rn pending
    drive(5'd9, 5'd10, 1'b1, 1'b1, 32'h99, 32'hAA, 1'b0, 1'b0);
    tick();
    idle();
    chk("rmid_busy_pre", 32'(wb_busy), 32'd1);
    nRESET = 1'b0;
    #1;
    chk("rmid_en",     32'(rf_wr_en), 32'd0);
    chk("rmid_busy",   32'(wb_busy), 32'd0);
    chk("rmid_data",   rf_wr_data, 32'd0);
    chk("rmid_result", wb_result, 32'd0);
    tick();
    nRESET = 1'b1;
    tick();
    chk("rmid_no_rn",  32'(rf_wr_en), 32'd0);
    chk("rmid_no_rn_addr", 32'(rf_wr_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
